display_sequencer: RTL

- Controller that drives the debug display mux's select (6 bits) and enable inputs on the DE2 board.
- Three modes:
  - Manual: switch-driven select.
  - Auto-scan: steps through the 7-entry debugging block (selects 32..38) on a dwell timer or on a key press.
  - Stage-locked: select tracks the processor's 0-4 stage counter, so each stage shows its datapath register.
- Sits between the board switches/keys, the stage counter and the display mux.

---
 rtl/display_seq_pkg.sv | 34 +++
 rtl/key_step_pulse.sv | 62 ++++++
 rtl/display_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/display_seq_pkg.sv
// Shared encodings for the debug display sequencer: mode codes, mux select codes
// and the stage-to-select map.
package display_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STAGE  = 2'b10
  } mode_e;

  localparam int         DEBUG_OFFSET = 32;
  localparam logic [5:0] ERR_SEL      = 6'd63;

  localparam logic [5:0] SEL_IR  = 6'd32;
  localparam logic [5:0] SEL_RA  = 6'd34;
  localparam logic [5:0] SEL_RZ  = 6'd36;
  localparam logic [5:0] SEL_RY  = 6'd37;
  localparam logic [5:0] SEL_RFV = 6'd38;

  // Stages 5..7 do not exist; the error code makes the mux show its error pattern.
  function automatic logic [5:0] stage_to_sel(input logic [2:0] stage);
    logic [5:0] sel;
    case (stage)
      3'd0:    sel = SEL_IR;
      3'd1:    sel = SEL_RA;
      3'd2:    sel = SEL_RZ;
      3'd3:    sel = SEL_RY;
      3'd4:    sel = SEL_RFV;
      default: sel = ERR_SEL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/key_step_pulse.sv
// Step key conditioning: 2-flop synchroniser, falling-edge detect, one registered
// pulse per press. STEP_DEBOUNCE_EN adds a stable-low debounce counter.
module key_step_pulse
`ifdef STEP_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 500000
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic step_pulse
);

  // Synchroniser resets to "pressed" so a key held through reset must be
  // released before it can fire.
  logic [1:0] r_sync;
  logic       r_pulse;

  assign step_pulse = r_pulse;

`ifdef STEP_DEBOUNCE_EN
  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  DB_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= DB_MAX;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_pulse <= 1'b0;
      if (r_sync[1]) begin
        r_cnt <= '0;
      end else if (r_cnt != DB_MAX) begin
        r_cnt   <= r_cnt + CW'(1);
        r_pulse <= (r_cnt == DB_LAST);
      end
    end
  end
`else
  logic r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_prev  <= r_sync[1];
      r_pulse <= r_prev & ~r_sync[1];
    end
  end
`endif

endmodule

// File: rtl/display_sequencer.sv
// Debug display mux controller: manual, auto-scan and stage-locked select with a
// registered enable. Optional step-key debounce via STEP_DEBOUNCE_EN.
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000000,
  parameter int SEQ_LEN      = 7,
  parameter int SEQ_BASE     = DEBUG_OFFSET
`ifdef STEP_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 500000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [5:0] manual_select,
  input  logic       step_key_n,
  input  logic       freeze,
  input  logic [2:0] stage,
  input  logic       rf_view_req,
  output logic [5:0] display_select,
  output logic       display_enable,
  output logic [2:0] seq_index,
  output logic       seq_wrap
);

  localparam int            DW         = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [2:0]    SEQ_LAST   = 3'(SEQ_LEN - 1);
  localparam logic [5:0]    BASE_SEL   = 6'(SEQ_BASE);

  logic [1:0]    r_mode;
  logic [DW-1:0] r_dwell;

  logic          w_step;
  logic          w_adv;
  logic          w_dwell_last;
  logic [DW-1:0] w_dwell_nxt;
  logic [2:0]    w_idx_nxt;
  logic          w_wrap_nxt;
  logic [5:0]    w_sel_nxt;

  key_step_pulse
`ifdef STEP_DEBOUNCE_EN
  #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
  u_key (
    .clock      (clock),
    .reset      (reset),
    .key_n      (step_key_n),
    .step_pulse (w_step)
  );

  always_comb begin
    w_dwell_last = (r_dwell == DWELL_LAST);
    w_adv        = 1'b0;
    w_dwell_nxt  = '0;
    w_idx_nxt    = seq_index;
    w_wrap_nxt   = 1'b0;
    w_sel_nxt    = manual_select;

    if (mode != r_mode) begin
      w_idx_nxt = '0;
    end else if (mode == MODE_AUTO) begin
      // A step and a dwell expiry in the same cycle collapse into one advance.
      w_adv = w_step | (~freeze & w_dwell_last);
      if (w_adv)       w_dwell_nxt = '0;
      else if (freeze) w_dwell_nxt = r_dwell;
      else             w_dwell_nxt = r_dwell + DW'(1);
      if (w_adv) begin
        if (seq_index == SEQ_LAST) begin
          w_idx_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_idx_nxt = seq_index + 3'd1;
        end
      end
    end

    case (mode)
      MODE_AUTO:  w_sel_nxt = BASE_SEL + {3'b000, w_idx_nxt};
      MODE_STAGE: w_sel_nxt = stage_to_sel(stage);
      default:    w_sel_nxt = manual_select;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode         <= MODE_MANUAL;
      r_dwell        <= '0;
      seq_index      <= '0;
      seq_wrap       <= 1'b0;
      display_select <= '0;
      display_enable <= 1'b0;
    end else begin
      r_mode         <= mode;
      r_dwell        <= w_dwell_nxt;
      seq_index      <= w_idx_nxt;
      seq_wrap       <= w_wrap_nxt;
      display_select <= w_sel_nxt;
      display_enable <= rf_view_req;
    end
  end

endmodule
